// File: rtl/tt_um_logarithmic_afpm.sv
// ----------------------------------------------------------------------------
// tt_um_logarithmic_afpm
//
// Byte-serial approximate FP16 multiplier using Mitchell's logarithmic
// approximation: the product fraction is the sum of the operand fractions
// rather than their product. A four-state frame loads each operand as two
// bytes (low first), computes, then streams the 16-bit product out as two
// bytes (low first).
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  tile enable (unused)
//   ui_in    in   8  operand A byte stream, low byte first
//   uio_in   in   8  operand B byte stream, low byte first
//   uo_out   out  8  product byte stream, low byte first (registered)
//   uio_out  out  8  constant 0x00
//   uio_oe   out  8  constant 0x00 (all uio pins are inputs)
// ----------------------------------------------------------------------------
module tt_um_logarithmic_afpm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] ST_LOAD_LO = 2'd0;
    localparam logic [1:0] ST_LOAD_HI = 2'd1;
    localparam logic [1:0] ST_CALC    = 2'd2;
    localparam logic [1:0] ST_OUT_HI  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] p_q, p_d;
    logic [7:0]  uo_q, uo_d;
    logic [15:0] prod;

    // Tile enable carries no meaning for this design.
    logic unused_ena;
    assign unused_ena = ena;

    assign uo_out  = uo_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // ------------------------------------------------------------------------
    // Mitchell multiply of the captured operands.
    // ------------------------------------------------------------------------
    logic        s_res;
    logic [4:0]  e_a, e_b;
    logic [9:0]  m_a, m_b;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [10:0] frac_sum;
    logic signed [6:0] exp_sum;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so
        // no path can leave a value unassigned and infer a latch.
        prod     = 16'h0000;
        s_res    = a_q[15] ^ b_q[15];
        e_a      = a_q[14:10];
        e_b      = b_q[14:10];
        m_a      = a_q[9:0];
        m_b      = b_q[9:0];
        nan_a    = (e_a == 5'h1F) && (m_a != 10'h0);
        nan_b    = (e_b == 5'h1F) && (m_b != 10'h0);
        inf_a    = (e_a == 5'h1F) && (m_a == 10'h0);
        inf_b    = (e_b == 5'h1F) && (m_b == 10'h0);
        zero_a   = (e_a == 5'h00) && (m_a == 10'h0);
        zero_b   = (e_b == 5'h00) && (m_b == 10'h0);
        frac_sum = {1'b0, m_a} + {1'b0, m_b};
        // Signed so that small exponents go negative and flag underflow.
        exp_sum  = $signed({2'b00, e_a}) + $signed({2'b00, e_b}) - 7'sd15;

        // Fraction carry is the log-domain equivalent of renormalising.
        if (frac_sum[10]) begin
            exp_sum  = exp_sum + 7'sd1;
            frac_sum = {1'b0, frac_sum[9:0]};
        end

        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            prod = 16'h7E00;
        end else if (inf_a || inf_b) begin
            prod = {s_res, 5'h1F, 10'h000};
        end else if ((e_a == 5'h00) || (e_b == 5'h00)) begin
            // Zeros and subnormals are flushed.
            prod = {s_res, 15'h0000};
        end else if (exp_sum >= 7'sd31) begin
            prod = {s_res, 5'h1F, 10'h000};
        end else if (exp_sum <= 7'sd0) begin
            prod = {s_res, 15'h0000};
        end else begin
            prod = {s_res, exp_sum[4:0], frac_sum[9:0]};
        end
    end

    // ------------------------------------------------------------------------
    // Frame sequencing; advances every cycle regardless of inputs.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        uo_d    = uo_q;
        case (state_q)
            ST_LOAD_LO: begin
                a_d[7:0] = ui_in;
                b_d[7:0] = uio_in;
                state_d  = ST_LOAD_HI;
            end
            ST_LOAD_HI: begin
                a_d[15:8] = ui_in;
                b_d[15:8] = uio_in;
                state_d   = ST_CALC;
            end
            ST_CALC: begin
                p_d     = prod;
                uo_d    = prod[7:0];
                state_d = ST_OUT_HI;
            end
            ST_OUT_HI: begin
                uo_d    = p_q[15:8];
                state_d = ST_LOAD_LO;
            end
            default: state_d = ST_LOAD_LO;
        endcase
    end

    // NOTE: all state, including the operand and product registers, is reset
    // so a mid-frame reset discards partial operands and uo_out reads 0x00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD_LO;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            p_q     <= 16'h0000;
            uo_q    <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            uo_q    <= uo_d;
        end
    end

endmodule

// File: tb/tb_tt_um_logarithmic_afpm.sv
// ----------------------------------------------------------------------------
// Directed testbench for tt_um_logarithmic_afpm. Each vector carries a
// hand-computed Mitchell product; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_tt_um_logarithmic_afpm;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec  = 0;
    int n_fail = 0;

    tt_um_logarithmic_afpm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge; the next rising edge must be a LOAD_LO edge.
    // Returns at the falling edge after the OUT_HI edge.
    task automatic run_frame(input string tag, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] exp);
        ui_in  = a[7:0];
        uio_in = b[7:0];
        tick();
        ui_in  = a[15:8];
        uio_in = b[15:8];
        tick();
        // Garbage during CALC must not matter.
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
        tick();
        check({tag, "_lo"}, uo_out, exp[7:0]);
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
        tick();
        check({tag, "_hi"}, uo_out, exp[15:8]);
        check({tag, "_uio_out"}, uio_out, 8'h00);
        check({tag, "_uio_oe"}, uio_oe, 8'h00);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b1;

        // Frames run back to back from here on.
        run_frame("mul_1p5x3",    16'h3E00, 16'h4200, 16'h4400);
        run_frame("mul_1x1",      16'h3C00, 16'h3C00, 16'h3C00);
        run_frame("mul_neg2x3",   16'hC000, 16'h4200, 16'hC600);
        run_frame("overflow",     16'h7800, 16'h7800, 16'h7C00);
        run_frame("underflow",    16'h0400, 16'h0400, 16'h0000);
        run_frame("zero_x_neg",   16'h0000, 16'hC200, 16'h8000);
        run_frame("inf_x_zero",   16'h7C00, 16'h0000, 16'h7E00);
        run_frame("nan_x_one",    16'h7E00, 16'h3C00, 16'h7E00);
        run_frame("neginf_x_2",   16'hFC00, 16'h4000, 16'hFC00);
        run_frame("b2b_a",        16'h3E00, 16'h4200, 16'h4400);
        run_frame("b2b_b",        16'h3C00, 16'h4000, 16'h4000);

        // Output holds across LOAD_LO / LOAD_HI edges of the next frame,
        // then reset mid-frame clears it immediately.
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick();
        check("hold_load_lo", uo_out, 8'h40);
        ui_in  = 8'h7C;
        uio_in = 8'h7C;
        tick();
        check("hold_load_hi", uo_out, 8'h40);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_uo", uo_out, 8'h00);
        check("midframe_reset_uio_oe", uio_oe, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("after_reset",  16'h3E00, 16'h4200, 16'h4400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
